// File: rtl/sim_run_controller.sv
// -----------------------------------------------------------------------------
// sim_run_controller
//
// Sequenced run controller for CPU simulation and FPGA bring-up. Holds the
// attached CPU(s) in reset for RST_CYCLES cycles, releases them, counts run
// cycles, watches every core's retire port for ECALL/EBREAK and reports
// pass / fail / timeout together with an exit code and the cycle count.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous, active-low reset
//   start        in   one-cycle pulse, begins a run from IDLE or DONE
//   instr        in   NUM_CORES*32 retired instructions, core i at [32i+31:32i]
//   instr_valid  in   NUM_CORES per-core retire strobes
//   exit_code    in   NUM_CORES*8 per-core a0[7:0], latched on halt
//   cpu_rst      out  active-high reset to the CPU instances
//   running      out  high while in RUN
//   done         out  high while in DONE
//   pass         out  all cores halted with exit code 0 (valid with done)
//   timeout      out  run ended by the cycle limit (valid with done)
//   halted       out  NUM_CORES sticky per-core halt flags
//   fail_code    out  exit code of the lowest-index core with nonzero code
//   cycle_count  out  RUN cycles elapsed (first RUN cycle shows 0)
// -----------------------------------------------------------------------------
module sim_run_controller #(
  parameter int NUM_CORES  = 1,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_CORES*32-1:0] instr,
  input  logic [NUM_CORES-1:0]   instr_valid,
  input  logic [NUM_CORES*8-1:0] exit_code,
  output logic                   cpu_rst,
  output logic                   running,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [NUM_CORES-1:0]   halted,
  output logic [7:0]             fail_code,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // The reset counter is loaded with RST_CYCLES-1 and counts down to zero,
  // so RESET lasts exactly RST_CYCLES cycles.
  localparam int              RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD  = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_CORES-1:0]   halted_q, halted_d;
  logic [7:0]             fail_code_q, fail_code_d;
  logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
  logic [7:0]             codes_q [NUM_CORES];
  logic [7:0]             codes_d [NUM_CORES];

  logic [NUM_CORES-1:0]   new_halt;
  logic [NUM_CORES-1:0]   halted_run;
  logic [7:0]             final_code;

  // ---------------------------------------------------------------------------
  // Halt detection and exit-code selection
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    new_halt   = '0;
    final_code = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      // Only the first halt of each core counts, and only while running.
      if (state_q == S_RUN && !halted_q[i] && instr_valid[i] &&
          (instr[32*i +: 32] == ECALL || instr[32*i +: 32] == EBREAK)) begin
        new_halt[i] = 1'b1;
      end
    end
    halted_run = halted_q | new_halt;
    for (int i = 0; i < NUM_CORES; i++) begin
      codes_d[i] = new_halt[i] ? exit_code[8*i +: 8] : codes_q[i];
    end
    // Walk from the top index down so the lowest nonzero core wins; codes of
    // cores that never halted are stale and must not contribute.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (halted_run[i] && codes_d[i] != 8'h00) begin
        final_code = codes_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking (=) assignments so later lines see
  // earlier results within the same evaluation; flops use non-blocking (<=).
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cpu_rst_d     = cpu_rst_q;
    running_d     = running_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    halted_d      = halted_q;
    fail_code_d   = fail_code_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE keeps the CPUs frozen and results visible until the next start.
        if (start) begin
          state_d       = S_RESET;
          rst_cnt_d     = RC_LOAD;
          cpu_rst_d     = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          halted_d      = '0;
          fail_code_d   = '0;
          cycle_count_d = '0;
        end
      end

      S_RESET: begin
        if (rst_cnt_q == '0) begin
          state_d       = S_RUN;
          cpu_rst_d     = 1'b0;
          running_d     = 1'b1;
          cycle_count_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end

      S_RUN: begin
        halted_d = halted_run;
        // A final halt on the last allowed cycle beats the timeout.
        if (&halted_run) begin
          state_d     = S_DONE;
          running_d   = 1'b0;
          done_d      = 1'b1;
          cpu_rst_d   = 1'b1;
          pass_d      = (final_code == 8'h00);
          timeout_d   = 1'b0;
          fail_code_d = final_code;
        end else if (cycle_count_q == CNT_LAST) begin
          state_d     = S_DONE;
          running_d   = 1'b0;
          done_d      = 1'b1;
          cpu_rst_d   = 1'b1;
          pass_d      = 1'b0;
          timeout_d   = 1'b1;
          fail_code_d = final_code;
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        cpu_rst_d = 1'b1;
        running_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cpu_rst_q     <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      halted_q      <= '0;
      fail_code_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cpu_rst_q     <= cpu_rst_d;
      running_q     <= running_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      halted_q      <= halted_d;
      fail_code_q   <= fail_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // NOTE: the latched exit codes are storage, not control state, and carry no
  // reset; they are only ever read qualified by the halted flags, which are.
  always_ff @(posedge clk) begin
    codes_q <= codes_d;
  end

  assign cpu_rst     = cpu_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign halted      = halted_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// -----------------------------------------------------------------------------
// tb_sim_run_controller
//
// Two controller instances share clk/rst/start: a single-core one with the
// default limits and a four-core one with TIMEOUT=50. Directed sequences cover
// reset, reset sequencing, mid-run abort and the single-core pass; a table of
// four-core scenarios and a batch of random scenarios are then run through the
// same task, with random scenarios scored by a run-level outcome model.
// -----------------------------------------------------------------------------
module tb_sim_run_controller;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          TO_M   = 50;
  localparam logic [7:0]  NEVER  = 8'd255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  // single-core instance
  logic [31:0] s_instr = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_code  = '0;
  logic        s_cpu_rst, s_running, s_done, s_pass, s_timeout;
  logic [0:0]  s_halted;
  logic [7:0]  s_fail_code;
  logic [31:0] s_cycle_count;

  // four-core instance
  logic [127:0] m_instr = '0;
  logic [3:0]   m_valid = '0;
  logic [31:0]  m_code  = '0;
  logic         m_cpu_rst, m_running, m_done, m_pass, m_timeout;
  logic [3:0]   m_halted;
  logic [7:0]   m_fail_code;
  logic [31:0]  m_cycle_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_run_controller #(.NUM_CORES(1), .RST_CYCLES(4), .TIMEOUT(1000), .CNT_W(32)) u_single (
    .clk(clk), .rst(rst), .start(start),
    .instr(s_instr), .instr_valid(s_valid), .exit_code(s_code),
    .cpu_rst(s_cpu_rst), .running(s_running), .done(s_done), .pass(s_pass),
    .timeout(s_timeout), .halted(s_halted), .fail_code(s_fail_code),
    .cycle_count(s_cycle_count)
  );

  sim_run_controller #(.NUM_CORES(4), .RST_CYCLES(4), .TIMEOUT(TO_M), .CNT_W(32)) u_multi (
    .clk(clk), .rst(rst), .start(start),
    .instr(m_instr), .instr_valid(m_valid), .exit_code(m_code),
    .cpu_rst(m_cpu_rst), .running(m_running), .done(m_done), .pass(m_pass),
    .timeout(m_timeout), .halted(m_halted), .fail_code(m_fail_code),
    .cycle_count(m_cycle_count)
  );

  typedef struct {
    logic [3:0][7:0] hc;      // RUN cycle at which each core halts (NEVER = no halt)
    logic [3:0][7:0] cd;      // exit code each core reports at its halt
    int              e_end;
    bit              e_pass;
    bit              e_to;
    logic [7:0]      e_fail;
    logic [3:0]      e_mask;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Run-level outcome: the run ends on the cycle of the last halt if every
  // core halts within the limit, otherwise on the last allowed cycle.
  function automatic void model(input logic [3:0][7:0] hc, input logic [3:0][7:0] cd,
                                output int e_end, output bit e_pass, output bit e_to,
                                output logic [7:0] e_fail, output logic [3:0] e_mask);
    int mx = 0;
    bit all_h = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (int'(hc[i]) > TO_M - 1) all_h = 1'b0;
      else if (int'(hc[i]) > mx) mx = int'(hc[i]);
    end
    e_to  = !all_h;
    e_end = all_h ? mx : TO_M - 1;
    e_mask = '0;
    for (int i = 0; i < 4; i++) e_mask[i] = (int'(hc[i]) <= e_end);
    e_fail = 8'h00;
    for (int i = 3; i >= 0; i--) if (cd[i] != 8'h00) e_fail = cd[i];
    e_pass = !e_to && (e_fail == 8'h00);
  endfunction

  // Drive the four retire ports for RUN cycle c: the scheduled halt, or noise
  // that must never count (non-halt opcodes, unqualified halts, re-halts).
  task automatic drive_multi(input logic [3:0][7:0] hc, input logic [3:0][7:0] cd, input int c);
    for (int i = 0; i < 4; i++) begin
      if (int'(hc[i]) == c) begin
        m_valid[i]         = 1'b1;
        m_instr[32*i +: 32] = ((i + c) % 2 == 1) ? ECALL : EBREAK;
        m_code[8*i +: 8]   = cd[i];
      end else begin
        m_code[8*i +: 8] = 8'($urandom_range(1, 255));
        case ($urandom_range(0, 3))
          0: begin m_valid[i] = 1'b0; m_instr[32*i +: 32] = ECALL; end
          1: begin
            m_valid[i] = 1'b1;
            m_instr[32*i +: 32] = ($urandom_range(0, 1) == 1) ? NOP : 32'h0020_0073;
          end
          2: begin
            m_valid[i] = 1'b1;
            m_instr[32*i +: 32] = (int'(hc[i]) < c) ? ECALL : NOP;
          end
          default: begin m_valid[i] = 1'b0; m_instr[32*i +: 32] = '0; end
        endcase
      end
    end
  endtask

  task automatic run_multi(input string tag, input logic [3:0][7:0] hc, input logic [3:0][7:0] cd,
                           input int e_end, input bit e_pass, input bit e_to,
                           input logic [7:0] e_fail, input logic [3:0] e_mask);
    int  n;
    int  c;
    bit  got;
    n = 0;
    while (m_running && n < 200) begin @(negedge clk); n++; end
    check({tag, "_idle_before"}, m_running, 0);
    if (m_running) return;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr_halted"}, m_halted, 0);
    check({tag, "_clr_done"}, m_done, 0);
    check({tag, "_clr_pass_to"}, {m_pass, m_timeout}, 0);

    // start pulses during RESET must be ignored
    n = 0;
    while (!m_running && n < 20) begin
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, "_reach_run"}, m_running, 1);
    if (!m_running) return;
    check({tag, "_cnt0"}, m_cycle_count, 0);

    c = 0;
    got = 1'b0;
    while (c < 200) begin
      drive_multi(hc, cd, c);
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      start = 1'b0;
      if (m_done) begin got = 1'b1; break; end
      c++;
    end
    m_valid = '0;
    check({tag, "_done_reached"}, got, 1);
    if (!got) return;
    check({tag, "_cycle_count"}, m_cycle_count, e_end);
    check({tag, "_pass"}, m_pass, e_pass);
    check({tag, "_timeout"}, m_timeout, e_to);
    check({tag, "_halted"}, m_halted, e_mask);
    check({tag, "_run_rst"}, {m_running, m_cpu_rst}, 2'b01);
    if (!e_to) check({tag, "_fail_code"}, m_fail_code, e_fail);

    // Results must hold in DONE whatever the retire ports do.
    m_valid = '1;
    m_instr = {4{ECALL}};
    m_code  = '1;
    @(negedge clk);
    m_valid = '0;
    check({tag, "_hold_cnt"}, m_cycle_count, e_end);
    check({tag, "_hold_halted"}, {m_done, m_halted}, {1'b1, e_mask});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int e_end;
    bit e_pass;
    bit e_to;
    logic [7:0] e_fail;
    logic [3:0] e_mask;
    logic [3:0][7:0] hc;
    logic [3:0][7:0] cd;

    // core order in the literals below is {core3, core2, core1, core0}
    vecs[0] = '{hc: {8'd25, 8'd10, 8'd7, 8'd3}, cd: '0, e_end: 25, e_pass: 1, e_to: 0, e_fail: 8'h00, e_mask: 4'hF};
    vecs[1] = '{hc: {8'd12, 8'd9, 8'd20, 8'd5}, cd: {8'h00, 8'h00, 8'h05, 8'h00}, e_end: 20, e_pass: 0, e_to: 0, e_fail: 8'h05, e_mask: 4'hF};
    vecs[2] = '{hc: {8'd30, NEVER, 8'd8, 8'd4}, cd: '0, e_end: 49, e_pass: 0, e_to: 1, e_fail: 8'h00, e_mask: 4'b1011};
    vecs[3] = '{hc: {8'd20, 8'd10, 8'd49, 8'd0}, cd: '0, e_end: 49, e_pass: 1, e_to: 0, e_fail: 8'h00, e_mask: 4'hF};
    vecs[4] = '{hc: {8'd7, 8'd7, 8'd7, 8'd7}, cd: {8'h09, 8'h00, 8'h03, 8'h00}, e_end: 7, e_pass: 0, e_to: 0, e_fail: 8'h03, e_mask: 4'hF};
    vecs[5] = '{hc: '0, cd: '0, e_end: 0, e_pass: 1, e_to: 0, e_fail: 8'h00, e_mask: 4'hF};
    vecs[6] = '{hc: {8'd40, 8'd2, 8'd3, 8'd1}, cd: {8'h80, 8'h00, 8'h00, 8'h00}, e_end: 40, e_pass: 0, e_to: 0, e_fail: 8'h80, e_mask: 4'hF};
    vecs[7] = '{hc: {8'd50, 8'd1, 8'd1, 8'd1}, cd: '0, e_end: 49, e_pass: 0, e_to: 1, e_fail: 8'h00, e_mask: 4'b0111};

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", m_cpu_rst, 1);
    check("rst_flags", {m_running, m_done, m_pass, m_timeout}, 0);
    check("rst_halted", m_halted, 0);
    check("rst_fail_code", m_fail_code, 0);
    check("rst_cycle_count", m_cycle_count, 0);
    check("rst_single", {s_cpu_rst, s_running, s_done, s_halted}, 4'b1000);
    rst = 1'b1;
    @(negedge clk);

    // ---- reset sequencing: cpu_rst held exactly 4 cycles after start ----
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    k = 0;
    while (!m_running && k < 20) begin
      if (m_cpu_rst) n++;
      @(negedge clk);
      k++;
    end
    check("seq_reset_cycles", n, 4);
    check("seq_running", m_running, 1);
    check("seq_cpu_rst_low", m_cpu_rst, 0);
    check("seq_cnt0", m_cycle_count, 0);
    repeat (5) @(negedge clk);
    check("seq_cnt5", m_cycle_count, 5);

    // ---- mid-run reset aborts everything ----
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_cpu_rst", m_cpu_rst, 1);
    check("abort_flags", {m_running, m_done, m_pass, m_timeout}, 0);
    check("abort_cycle_count", m_cycle_count, 0);
    @(negedge clk);
    check("abort_stays_idle", {m_running, m_cpu_rst}, 2'b01);

    // ---- single-core pass at RUN cycle 25 ----
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!s_running && k < 20) begin @(negedge clk); k++; end
    check("single_running", s_running, 1);
    check("single_cnt0", s_cycle_count, 0);
    for (int c = 0; c <= 25; c++) begin
      if (c == 25) check("single_nop_no_halt", {s_done, s_halted}, 0);
      s_valid = (c % 3 == 0);
      s_instr = NOP;
      s_code  = 8'h11;
      if (c == 10) begin s_valid = 1'b0; s_instr = ECALL; end
      if (c == 25) begin s_valid = 1'b1; s_instr = EBREAK; s_code = 8'h00; end
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("single_done", s_done, 1);
    check("single_pass_to", {s_pass, s_timeout}, 2'b10);
    check("single_halted", s_halted, 1);
    check("single_cycle_count", s_cycle_count, 25);
    check("single_fail_code", s_fail_code, 0);

    // ---- four-core directed table ----
    for (int v = 0; v < 8; v++) begin
      run_multi($sformatf("vec%0d", v), vecs[v].hc, vecs[v].cd, vecs[v].e_end,
                vecs[v].e_pass, vecs[v].e_to, vecs[v].e_fail, vecs[v].e_mask);
    end

    // ---- four-core random scenarios against the outcome model ----
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin
        hc[i] = 8'($urandom_range(0, 56));
        cd[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      model(hc, cd, e_end, e_pass, e_to, e_fail, e_mask);
      run_multi($sformatf("rnd%0d", r), hc, cd, e_end, e_pass, e_to, e_fail, e_mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
